// File: rtl/pipe_stage_reg.sv
// Pipeline stage register between two core stages. Carries a data and a
// control bundle under a valid/ready handshake, with a hazard stall (hold),
// a branch flush and an optional second "skid" entry so in_ready can come
// straight from a flop. Control is forced to zero whenever nothing valid
// is presented, so an empty stage looks like a NOP to the next stage.
module pipe_stage_reg #(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 16,
    parameter bit SKID_EN = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [15:0]       flush_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    state_t      state_q, state_d;
    beat_t       main_q, main_d;
    beat_t       skid_q, skid_d;
    logic [15:0] fcnt_q, fcnt_d;
    beat_t       in_beat;
    logic        drain;
    logic        accept;

    assign in_beat   = '{ctrl: in_ctrl, data: in_data};
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q.data;
    assign out_ctrl  = out_valid ? main_q.ctrl : '0;
    assign occupancy = {state_q == SKID, state_q == FULL};
    assign flush_count = fcnt_q;

    // A held beat is not transferred even if downstream is ready.
    assign drain  = out_valid & out_ready & ~hold;
    assign accept = in_valid & in_ready & ~flush;

    generate
        if (SKID_EN) begin : g_skid
            logic rdy_q;
            // Registered ready: high unless the next state has both entries full.
            // Reset value is 1 so the stage is ready as soon as reset drops.
            always_ff @(posedge clk) begin
                if (!reset_n) rdy_q <= 1'b1;
                else          rdy_q <= (state_d != SKID);
            end
            assign in_ready = reset_n & rdy_q;
        end else begin : g_noskid
            assign in_ready = reset_n & ((state_q != FULL) | drain);
        end
    endgenerate

    // Next state, entry contents and flush counter.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_beat;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept && drain) begin
                    main_d = in_beat;
                end else if (drain) begin
                    state_d = EMPTY;
                end else if (accept && SKID_EN) begin
                    skid_d  = in_beat;
                    state_d = SKID;
                end
            end
            SKID: begin
                // in_ready is low here, so only the drain side can move.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides everything; count it only if it actually killed a beat.
        if (flush) begin
            state_d = EMPTY;
            if (((state_q != EMPTY) || in_valid) && (fcnt_q != 16'hFFFF))
                fcnt_d = fcnt_q + 16'd1;
        end
    end

    // State and payload registers; reset beats every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one single-entry and one skid instance
// share the stimulus; a scoreboard queue per instance holds expected beats.
module tb_pipe_stage_reg;

    typedef struct {
        logic [63:0] d;
        logic [15:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, out_ready, hold, flush;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;

    logic        rdy0, ov0, rdy1, ov1;
    logic [63:0] od0, od1;
    logic [15:0] oc0, oc1, fc0, fc1;
    logic [1:0]  occ0, occ1;

    exp_t sb0[$];
    exp_t sb1[$];
    bit   mon0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID_EN(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_ctrl(oc0), .hold(hold), .flush(flush),
        .occupancy(occ0), .flush_count(fc0));

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID_EN(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ctrl(oc1), .hold(hold), .flush(flush),
        .occupancy(occ1), .flush_count(fc1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic ordy,
                         input logic hld, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = d[15:0];
        out_ready = ordy;
        hold      = hld;
        flush     = fl;
    endtask

    // One clock: mid-cycle, pop/compare any beat leaving a DUT; then the edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (ov1 && out_ready && !hold) begin
            if (sb1.size() == 0) check("skid_extra_beat", 64'(sb1.size()), 64'd1);
            else begin
                e = sb1.pop_front();
                check("skid_out_data", od1, e.d);
                check("skid_out_ctrl", 64'(oc1), 64'(e.c));
            end
        end
        if (mon0 && ov0 && out_ready && !hold) begin
            if (sb0.size() == 0) check("single_extra_beat", 64'(sb0.size()), 64'd1);
            else begin
                e = sb0.pop_front();
                check("single_out_data", od0, e.d);
                check("single_out_ctrl", 64'(oc0), 64'(e.c));
            end
        end
        if (flush || !reset_n) begin
            sb0.delete();
            sb1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input bit both);
        exp_t e;
        e.d = d;
        e.c = d[15:0];
        sb1.push_back(e);
        if (both) sb0.push_back(e);
    endtask

    initial begin
        mon0    = 1'b0;
        reset_n = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_out_valid", 64'(ov1), 64'd0);
        check("rst_out_ctrl", 64'(oc1), 64'd0);
        check("rst_out_data", od1, 64'd0);
        check("rst_occupancy", 64'(occ1), 64'd0);
        check("rst_flush_count", 64'(fc1), 64'd0);
        check("rst_in_ready_skid", 64'(rdy1), 64'd0);
        check("rst_in_ready_single", 64'(rdy0), 64'd0);
        reset_n = 1'b1;
        cyc();
        check("post_rst_in_ready_skid", 64'(rdy1), 64'd1);
        check("post_rst_in_ready_single", 64'(rdy0), 64'd1);
        check("post_rst_occupancy", 64'(occ0), 64'd0);

        // Streaming, both modes
        mon0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
            push(64'(i), 1'b1);
            #2;
            check("stream_in_ready_skid", 64'(rdy1), 64'd1);
            check("stream_in_ready_single", 64'(rdy0), 64'd1);
            if (i > 1) begin
                check("stream_valid_skid", 64'(ov1), 64'd1);
                check("stream_valid_single", 64'(ov0), 64'd1);
            end
            cyc();
        end
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        check("stream_sb_skid_empty", 64'(sb1.size()), 64'd0);
        check("stream_sb_single_empty", 64'(sb0.size()), 64'd0);
        mon0 = 1'b0;

        // Backpressure on the skid instance: A, B accepted, C waits
        drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0); push(64'hA, 1'b0); #2;
        check("bp_rdy_A", 64'(rdy1), 64'd1);
        cyc();
        drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0); push(64'hB, 1'b0); #2;
        check("bp_rdy_B", 64'(rdy1), 64'd1);
        cyc();
        drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0); push(64'hC, 1'b0); #2;
        check("bp_rdy_C", 64'(rdy1), 64'd0);
        check("bp_occupancy", 64'(occ1), 64'd2);
        cyc();
        check("bp_rdy_C_still", 64'(rdy1), 64'd0);
        out_ready = 1'b1;
        cyc();
        check("bp_rdy_after_drain", 64'(rdy1), 64'd1);
        cyc();
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        check("bp_sb_empty", 64'(sb1.size()), 64'd0);
        check("bp_bubble_ctrl", 64'(oc1), 64'd0);

        // Hold for 3 cycles with out_ready=1
        drive(1'b1, 64'hD, 1'b1, 1'b0, 1'b0); push(64'hD, 1'b0);
        cyc();
        drive(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("hold_valid", 64'(ov1), 64'd1);
            check("hold_data", od1, 64'hD);
            cyc();
        end
        hold = 1'b0;
        #2;
        check("hold_release_valid", 64'(ov1), 64'd1);
        cyc();
        check("hold_drained", 64'(ov1), 64'd0);
        check("hold_sb_empty", 64'(sb1.size()), 64'd0);

        // Flush with both entries held and beat 9 offered
        drive(1'b1, 64'hE, 1'b0, 1'b0, 1'b0); push(64'hE, 1'b0);
        cyc();
        drive(1'b1, 64'hF, 1'b0, 1'b0, 1'b0); push(64'hF, 1'b0);
        cyc();
        check("flush_pre_occ", 64'(occ1), 64'd2);
        drive(1'b1, 64'd9, 1'b0, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        #2;
        check("flush_occ", 64'(occ1), 64'd0);
        check("flush_valid", 64'(ov1), 64'd0);
        check("flush_ctrl", 64'(oc1), 64'd0);
        check("flush_count_1", 64'(fc1), 64'd1);
        repeat (3) cyc();
        // Empty, no offer: not counted
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #2;
        check("flush_noop_count", 64'(fc1), 64'd1);

        // Reset mid-operation while FULL, coinciding with a flush
        drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0); push(64'h11, 1'b0);
        cyc();
        check("mid_full_occ", 64'(occ1), 64'd1);
        reset_n = 1'b0;
        drive(1'b1, 64'h12, 1'b0, 1'b0, 1'b1);
        cyc();
        check("mid_rst_valid", 64'(ov1), 64'd0);
        check("mid_rst_count", 64'(fc1), 64'd0);
        check("mid_rst_rdy", 64'(rdy1), 64'd0);
        check("mid_rst_occ", 64'(occ1), 64'd0);
        reset_n = 1'b1;
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        check("mid_rel_rdy_skid", 64'(rdy1), 64'd1);
        check("mid_rel_rdy_single", 64'(rdy0), 64'd1);
        check("mid_rel_count", 64'(fc1), 64'd0);

        // Saturation of the flush counter
        drive(1'b1, 64'h77, 1'b1, 1'b0, 1'b1);
        repeat (65534) cyc();
        check("sat_fffe", 64'(fc1), 64'hFFFE);
        repeat (2) cyc();
        check("sat_ffff", 64'(fc1), 64'hFFFF);
        repeat (3) cyc();
        check("sat_stays", 64'(fc1), 64'hFFFF);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        check("end_sb_empty", 64'(sb1.size()), 64'd0);
        check("end_valid", 64'(ov1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
